inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction-fetch initiator for chinocpu.
- Owns the PC and drives chip-enable and byte address to the combinational instruction ROM, which returns 64-bit instructions from `addr[InstMemNumLog2+2:3]`.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stalls, branch redirects and pipeline flushes, and feeds the decode stage.

Parameters:
- ADDR_W, 64, width of PC and ROM address.
- INST_W, 64, instruction width.
- INST_BYTES, 8, PC increment per sequential fetch.
- RESET_VECTOR, 64'h0, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_if  in  1  hold PC and fetch.
- stall_id  in  1  decode stage stalled; hold IF/ID.
- branch_flag  in  1  taken branch resolved in ID this cycle.
- branch_target  in  ADDR_W  branch destination.
- flush  in  1  exception or eret flush.
- new_pc  in  ADDR_W  flush destination.
- rom_ce  out  1  ROM chip enable, registered.
- rom_addr  out  ADDR_W  ROM byte address, equal to pc.
- rom_inst  in  INST_W  ROM data, valid in the same cycle as rom_addr.
- id_pc  out  ADDR_W  PC of the instruction in IF/ID.
- id_inst  out  INST_W  instruction in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst=1):
  - rom_ce=0, pc=RESET_VECTOR.
  - id_pc=0, id_inst=ZeroDoubleWord, id_valid=0.
  - State is BOOT.
- State machine (2 bits): BOOT, RUN, HOLD.
  - BOOT: rom_ce=0, no capture. Next edge: rom_ce<=1, go to RUN. pc is unchanged.
  - RUN: rom_addr=pc, combinational from the pc register. At the edge with no stall/branch/flush:
    - id_inst<=rom_inst, id_pc<=pc, id_valid<=1.
    - pc<=pc+INST_BYTES, wrapping modulo 2^ADDR_W.
  - RUN with stall_if=1: go to HOLD. pc holds and rom_ce stays 1.
    - If stall_id=0: IF/ID gets a bubble (id_valid<=0, id_inst<=0).
    - If stall_id=1: IF/ID holds.
  - HOLD: same stall rules as above. Return to RUN on the first edge with stall_if=0; capture resumes that edge.
- Event priority per edge: flush > branch_flag > stall_if > normal advance.
  - flush: pc<=new_pc, IF/ID bubble. Applies regardless of stalls, and also in BOOT. State becomes RUN and rom_ce<=1.
  - branch_flag: honoured only when stall_id=0. pc<=branch_target, IF/ID bubble.
    - There is no delay slot: the instruction fetched in the branch cycle is squashed.
  - branch_flag with stall_id=1: ignored. ID re-presents the branch when it unstalls.
- Latency:
  - A redirect costs exactly one bubble cycle.
  - The first valid id_inst appears two edges after rst deasserts: BOOT, then the first capture.
- Fetches while rom_ce=0 never produce id_valid=1.
- rom_addr bits [2:0] are always driven 0.
- rst asserted mid-operation: all state returns to reset values immediately, and any in-flight instruction is discarded.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Enabled:
  - Adds output port fetch_misalign (1) and output port bad_addr (ADDR_W).
  - A flush or branch target with nonzero [2:0] pulses fetch_misalign for one cycle and registers bad_addr with the raw target.
  - pc<=target with [2:0] cleared; IF/ID bubble as normal.
  - fetch_misalign and bad_addr reset to 0.
- Disabled: the ports are absent and target [2:0] is silently cleared.

Decomposition:
- defines.v supplies:
  - widths: InstAddrBus, InstBus;
  - control levels: RstEnable, ChipEnable, ChipDisable;
  - constants: ZeroDoubleWord, ResetVector, InstBytes;
  - state encodings: FetchBoot, FetchRun, FetchHold.
- One sub-module, pc_reg: the PC register, next-PC mux (flush/branch/increment/hold), alignment clearing and rom_ce generation.
- inst_fetch keeps the FSM and IF/ID register.

Test Plan:
- Reset release with ROM word0=64'h2110000010000000 and word1=0:
  - edge1: rom_ce=1, id_valid=0.
  - edge2: id_inst=64'h2110000010000000, id_pc=0.
  - edge3: id_pc=8, id_inst=0.
- Pulse branch_flag with target=64'h40 while pc=0x10:
  - next edge: id_valid=0, pc=0x40.
  - following edge: id_pc=0x40, id_inst=64'h2080800004000000.
- stall_if=1 and stall_id=0 for 3 cycles at pc=0x58:
  - three bubbles; pc stays 0x58.
  - on release, id_pc=0x58.
  - Repeat with stall_id=1: id_inst and id_pc frozen.
- Same-cycle flush (new_pc=0x100) and branch (target=0x40) with stall_if=1: pc=0x100, bubble, capture of word 32 next edge.
- pc=64'hFFFF_FFFF_FFFF_FFF8 sequential advance: pc wraps to 0.
- Macro on, branch target 0x43: fetch_misalign pulses for 1 cycle, bad_addr=0x43, pc=0x40. Macro off: pc=0x40 and no extra ports.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the chinocpu instruction-fetch stage: bus widths,
// control levels, reset constants, FSM and next-PC select encodings.
package inst_fetch_pkg;

    // Widths
    localparam int unsigned InstAddrBus = 64;
    localparam int unsigned InstBus     = 64;

    // Control levels
    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // Constants
    localparam logic [63:0] ZeroDoubleWord = 64'h0;
    localparam logic [63:0] ResetVector    = 64'h0;
    localparam int unsigned InstBytes      = 8;

    // Fetch FSM state encodings
    typedef enum logic [1:0] {
        FetchBoot = 2'd0,
        FetchRun  = 2'd1,
        FetchHold = 2'd2
    } fetch_state_e;

    // Next-PC source selected by the fetch FSM
    typedef enum logic [1:0] {
        PcHold   = 2'd0,
        PcInc    = 2'd1,
        PcBranch = 2'd2,
        PcFlush  = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: pipeline control in, ROM request/response, IF/ID out.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_misalign and bad_addr.
interface inst_fetch_if
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus,
    parameter int unsigned INST_W = InstBus
) ();

    logic              stall_if;
    logic              stall_id;
    logic              branch_flag;
    logic [ADDR_W-1:0] branch_target;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              fetch_misalign;
    logic [ADDR_W-1:0] bad_addr;
`endif

    // Fetch unit side
    modport master (
        input  stall_if, stall_id, branch_flag, branch_target, flush, new_pc, rom_inst,
        output rom_ce, rom_addr, id_pc, id_inst, id_valid
`ifdef FETCH_ALIGN_CHECK_EN
        , output fetch_misalign, bad_addr
`endif
    );

    // Pipeline / ROM side
    modport slave (
        output stall_if, stall_id, branch_flag, branch_target, flush, new_pc, rom_inst,
        input  rom_ce, rom_addr, id_pc, id_inst, id_valid
`ifdef FETCH_ALIGN_CHECK_EN
        , input fetch_misalign, bad_addr
`endif
    );

endinterface

// File: rtl/inst_fetch_pc_reg.sv
// PC register with next-PC mux (hold/increment/branch/flush), redirect target
// alignment and ROM chip-enable generation.
// Optional macro FETCH_ALIGN_CHECK_EN reports misaligned redirect targets.
module inst_fetch_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W       = InstAddrBus,
    parameter int unsigned        INST_BYTES   = InstBytes,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(ResetVector)
) (
    input  logic              clk,
    input  logic              rst,
    input  pc_sel_e           pc_sel,
    input  logic              ce_set,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              rom_ce
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic              fetch_misalign,
    output logic [ADDR_W-1:0] bad_addr
`endif
);

    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(7);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] raw_target;
    logic              redirect;
    logic              rom_ce_q;

    // Pick the redirect source and form the next PC
    always_comb begin
        raw_target = (pc_sel == PcFlush) ? new_pc : branch_target;
        redirect   = (pc_sel == PcFlush) || (pc_sel == PcBranch);
        pc_d       = pc_q;
        unique case (pc_sel)
            PcHold:           pc_d = pc_q;
            PcInc:            pc_d = pc_q + ADDR_W'(INST_BYTES);
            PcBranch, PcFlush: pc_d = raw_target & AlignMask;
        endcase
    end

    // PC and chip-enable state; chip-enable is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pc_q     <= RESET_VECTOR;
            rom_ce_q <= ChipDisable;
        end else begin
            pc_q <= pc_d;
            if (ce_set) begin
                rom_ce_q <= ChipEnable;
            end
        end
    end

    assign pc     = pc_q;
    assign rom_ce = rom_ce_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic              misalign_q;
    logic [ADDR_W-1:0] bad_addr_q;

    // One-cycle pulse on a misaligned redirect; bad_addr keeps the raw target
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            misalign_q <= redirect && (raw_target[2:0] != 3'b000);
            if (redirect && (raw_target[2:0] != 3'b000)) begin
                bad_addr_q <= raw_target;
            end
        end
    end

    assign fetch_misalign = misalign_q;
    assign bad_addr       = bad_addr_q;
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: boot/run/hold FSM, event prioritisation
// (flush > branch > stall_if > advance) and the IF/ID pipeline register.
// Optional macro FETCH_ALIGN_CHECK_EN exposes fetch_misalign/bad_addr.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W       = InstAddrBus,
    parameter int unsigned        INST_W       = InstBus,
    parameter int unsigned        INST_BYTES   = InstBytes,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(ResetVector)
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);

    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(7);

    fetch_state_e      state_q, state_d;
    pc_sel_e           pc_sel;
    logic              ce_set;
    logic              id_load;
    logic              id_bubble;
    logic              take_branch;
    logic [ADDR_W-1:0] pc;

    logic [ADDR_W-1:0] id_pc_q;
    logic [INST_W-1:0] id_inst_q;
    logic              id_valid_q;

    inst_fetch_pc_reg #(
        .ADDR_W       (ADDR_W),
        .INST_BYTES   (INST_BYTES),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .pc_sel        (pc_sel),
        .ce_set        (ce_set),
        .branch_target (bus.branch_target),
        .new_pc        (bus.new_pc),
        .pc            (pc),
        .rom_ce        (bus.rom_ce)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign (bus.fetch_misalign),
        .bad_addr       (bus.bad_addr)
`endif
    );

    // A branch in ID only counts when ID itself is not stalled
    assign take_branch = bus.branch_flag && !bus.stall_id;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q <= FetchBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, PC source and IF/ID control
    always_comb begin
        state_d   = state_q;
        pc_sel    = PcHold;
        ce_set    = 1'b0;
        id_load   = 1'b0;
        id_bubble = 1'b0;
        if (bus.flush) begin
            pc_sel    = PcFlush;
            ce_set    = 1'b1;
            id_bubble = 1'b1;
            state_d   = FetchRun;
        end else begin
            unique case (state_q)
                FetchBoot: begin
                    ce_set  = 1'b1;
                    state_d = FetchRun;
                end
                FetchRun, FetchHold: begin
                    if (take_branch) begin
                        pc_sel    = PcBranch;
                        id_bubble = 1'b1;
                        state_d   = FetchRun;
                    end else if (bus.stall_if) begin
                        state_d   = FetchHold;
                        id_bubble = !bus.stall_id;
                    end else if (bus.stall_id) begin
                        // Decode cannot accept: hold both PC and IF/ID
                        state_d = FetchRun;
                    end else begin
                        pc_sel  = PcInc;
                        id_load = 1'b1;
                        state_d = FetchRun;
                    end
                end
                default: state_d = FetchBoot;
            endcase
        end
    end

    // IF/ID pipeline register; a bubble clears the instruction and valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            id_pc_q    <= '0;
            id_inst_q  <= INST_W'(ZeroDoubleWord);
            id_valid_q <= 1'b0;
        end else if (id_bubble) begin
            id_inst_q  <= INST_W'(ZeroDoubleWord);
            id_valid_q <= 1'b0;
        end else if (id_load) begin
            id_pc_q    <= pc;
            id_inst_q  <= bus.rom_inst;
            id_valid_q <= 1'b1;
        end
    end

    assign bus.rom_addr = pc & AlignMask;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_valid = id_valid_q;

endmodule
